// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings, responder FSM states and byte-lane helpers shared by
// the SRAM slave.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } ahb_state_e;

   function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << offset;
         HSIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] merge_lanes(input logic [31:0] base, input logic [31:0] upd,
                                                input logic [3:0] be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? upd[8*i +: 8] : base[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Behavioural single-port RAM: 32-bit words, per-byte write enables,
// registered read on non-write cycles, no reset. Drop-in point for a BRAM macro.
module sram_1rw_be #(
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  ce,
   input  logic [3:0]            we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem_r [2**ADDR_WIDTH];

   // byte-lane write, or read into the output register when no lane is written
   always_ff @(posedge clk) begin
      if (ce) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         if (we == 4'b0000) rdata <= mem_r[addr];
      end
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder for the boot RAM. Defining AHB_SRAM_WPROT_EN adds the
// wp_lock input that turns accepted writes into ERROR responses.
module ahb_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 13,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
`ifdef AHB_SRAM_WPROT_EN
   input  logic        wp_lock,
`endif
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   localparam logic [2:0] WS_L      = 3'(WAIT_STATES);
   localparam int         WIN_SHIFT = ADDR_WIDTH + 2;

   ahb_state_e            state_r, state_next_s;
   logic [2:0]            cnt_r;
   logic [ADDR_WIDTH-1:0] addr_r, wbuf_addr_r, ram_addr_s, haddr_word_s;
   logic [3:0]            be_r, wbuf_be_r, ram_be_s, fwd_be_s;
   logic                  hwrite_r, hreadyout_r, hresp_r, wbuf_vld_r;
   logic [31:0]           hold_r, wbuf_data_r, ram_wdata_s, ram_rdata_s, hrdata_s;
   logic                  trans_active_s, aligned_s, in_window_s, wr_prot_s, legal_s, accept_s;
   logic                  rd_issue_s, wr_done_s, rd_phase_s, ram_ce_s;

   assign haddr_word_s = haddr[ADDR_WIDTH+1:2];
   assign in_window_s  = (haddr >> WIN_SHIFT) == (BASE_ADDR >> WIN_SHIFT);
`ifdef AHB_SRAM_WPROT_EN
   assign wr_prot_s = hwrite & wp_lock;
`else
   assign wr_prot_s = 1'b0;
`endif

   // address-phase decode and legality
   always_comb begin
      trans_active_s = 1'b0;
      aligned_s      = 1'b1;
      case (htrans)
         HTRANS_NONSEQ, HTRANS_SEQ: trans_active_s = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  trans_active_s = 1'b0;
         default:                   trans_active_s = 1'b0;
      endcase
      case (hsize)
         HSIZE_HALF: aligned_s = ~haddr[0];
         HSIZE_WORD: aligned_s = (haddr[1:0] == 2'b00);
         default:    aligned_s = 1'b1;
      endcase
   end

   assign accept_s = hsel & trans_active_s & hready & hreadyout_r;
   assign legal_s  = (hsize <= HSIZE_WORD) & aligned_s & in_window_s & ~wr_prot_s;

   // next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (accept_s) begin
               if (!legal_s)              state_next_s = ST_ERR1;
               else if (WS_L != 3'd0)     state_next_s = ST_WAIT;
               else                       state_next_s = ST_DATA;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 3'd1) state_next_s = ST_DATA;
            else               state_next_s = ST_WAIT;
         end
         ST_ERR1: state_next_s = ST_ERR2;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM, wait counter, latched address phase and registered handshake outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 3'd0;
         addr_r      <= '0;
         be_r        <= 4'b0000;
         hwrite_r    <= 1'b0;
         hreadyout_r <= 1'b1;
         hresp_r     <= HRESP_OKAY;
      end else begin
         state_r     <= state_next_s;
         hreadyout_r <= (state_next_s != ST_WAIT) && (state_next_s != ST_ERR1);
         hresp_r     <= ((state_next_s == ST_ERR1) || (state_next_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
         if (accept_s & legal_s)    cnt_r <= WS_L;
         else if (state_r == ST_WAIT) cnt_r <= cnt_r - 3'd1;
         if (accept_s) begin
            addr_r   <= haddr_word_s;
            be_r     <= byte_enables(hsize, haddr[1:0]);
            hwrite_r <= hwrite;
         end
      end
   end

   // The single RAM port belongs to reads when one is issued; a write whose
   // data phase collides with a read is parked in wbuf and retired next free cycle.
   assign rd_issue_s = (accept_s & legal_s & ~hwrite & (WS_L == 3'd0)) |
                       ((state_r == ST_WAIT) & (cnt_r == 3'd1) & ~hwrite_r);
   assign wr_done_s  = (state_r == ST_DATA) & hwrite_r;
   assign rd_phase_s = (state_r == ST_DATA) & ~hwrite_r;

   // RAM port arbitration
   always_comb begin
      ram_addr_s  = addr_r;
      ram_wdata_s = hwdata;
      ram_be_s    = 4'b0000;
      if (rd_issue_s) begin
         ram_addr_s = (state_r == ST_WAIT) ? addr_r : haddr_word_s;
      end else if (wbuf_vld_r) begin
         ram_addr_s  = wbuf_addr_r;
         ram_wdata_s = wbuf_data_r;
         ram_be_s    = wbuf_be_r;
      end else if (wr_done_s) begin
         ram_be_s = be_r;
      end else begin
         ram_be_s = 4'b0000;
      end
   end

   assign ram_ce_s = rd_issue_s | (ram_be_s != 4'b0000);

   // posted-write buffer and read-data hold register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wbuf_vld_r  <= 1'b0;
         wbuf_addr_r <= '0;
         wbuf_data_r <= 32'h0000_0000;
         wbuf_be_r   <= 4'b0000;
         hold_r      <= 32'h0000_0000;
      end else begin
         hold_r <= hrdata_s;
         if (wr_done_s & (rd_issue_s | wbuf_vld_r)) begin
            wbuf_vld_r  <= 1'b1;
            wbuf_addr_r <= addr_r;
            wbuf_data_r <= hwdata;
            wbuf_be_r   <= be_r;
         end else if (!rd_issue_s) begin
            wbuf_vld_r <= 1'b0;
         end
      end
   end

   assign fwd_be_s = (wbuf_vld_r && (wbuf_addr_r == addr_r)) ? wbuf_be_r : 4'b0000;
   assign hrdata_s = rd_phase_s ? merge_lanes(ram_rdata_s, wbuf_data_r, fwd_be_s) : hold_r;

   sram_1rw_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .ce    (ram_ce_s),
      .we    (ram_be_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   assign hreadyout = hreadyout_r;
   assign hresp     = hresp_r;
   assign hrdata    = hrdata_s;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a zero-wait instance and a three-wait instance share the
// bus stimulus; each is selected in turn with its own hsel.
module tb_ahb_sram_slave;
   import ahb_lite_pkg::*;

   logic        clk = 1'b0;
   logic        reset0, reset1, hsel0, hsel1, hwrite;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic        hreadyout0, hreadyout1, hresp0, hresp1;
   logic [31:0] hrdata0, hrdata1;
`ifdef AHB_SRAM_WPROT_EN
   logic        wp_lock;
`endif
   int          total = 0;
   int          bad = 0;
   int          n;

   always #5 clk = ~clk;

   ahb_sram_slave #(.ADDR_WIDTH(13), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset0),
`ifdef AHB_SRAM_WPROT_EN
      .wp_lock(wp_lock),
`endif
      .hsel(hsel0), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
      .hwdata(hwdata), .hready(hreadyout0), .hreadyout(hreadyout0), .hresp(hresp0),
      .hrdata(hrdata0));

   ahb_sram_slave #(.ADDR_WIDTH(13), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) dut1 (
      .clk(clk), .reset(reset1),
`ifdef AHB_SRAM_WPROT_EN
      .wp_lock(1'b0),
`endif
      .hsel(hsel1), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
      .hwdata(hwdata), .hready(hreadyout1), .hreadyout(hreadyout1), .hresp(hresp1),
      .hrdata(hrdata1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      htrans = HTRANS_NONSEQ;
   endtask

   task automatic idle();
      htrans = HTRANS_IDLE;
   endtask

   task automatic wait_ready1(output int cyc);
      cyc = 0;
      while (hreadyout1 !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      reset0 = 1'b0; reset1 = 1'b0; hsel0 = 1'b0; hsel1 = 1'b0;
      haddr = 32'h0; hwrite = 1'b0; hsize = HSIZE_WORD; htrans = HTRANS_IDLE; hwdata = 32'h0;
`ifdef AHB_SRAM_WPROT_EN
      wp_lock = 1'b0;
`endif
      tick(); tick();
      chk("rst_ready0", 32'(hreadyout0), 32'd1);
      chk("rst_resp0",  32'(hresp0),     32'd0);
      chk("rst_rdata0", hrdata0,         32'h0);
      chk("rst_ready1", 32'(hreadyout1), 32'd1);
      reset0 = 1'b1; reset1 = 1'b1;
      hsel0 = 1'b1;
      tick();
      chk("idle_okay", 32'(hreadyout0), 32'd1);

      addr_ph(32'h0, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'h00C0_FFEE; idle(); tick();

      addr_ph(32'h200, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'hDEAD_BEEF; idle();
      chk("wr_ready", 32'(hreadyout0), 32'd1);
      chk("wr_resp",  32'(hresp0),     32'd0);
      tick();
      addr_ph(32'h200, 1'b0, HSIZE_WORD); tick();
      idle();
      chk("rd_word", hrdata0, 32'hDEAD_BEEF);
      chk("rd_resp", 32'(hresp0), 32'd0);
      tick();

      addr_ph(32'h200, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'h1122_3344; addr_ph(32'h201, 1'b1, HSIZE_BYTE); tick();
      hwdata = 32'h0000_AA00; addr_ph(32'h202, 1'b1, HSIZE_HALF); tick();
      hwdata = 32'h5566_0000; addr_ph(32'h200, 1'b0, HSIZE_WORD); tick();
      idle();
      chk("rd_lanes_fwd", hrdata0, 32'h5566_AA44);
      chk("rd_lanes_nostall", 32'(hreadyout0), 32'd1);
      tick();
      chk("hold_idle", hrdata0, 32'h5566_AA44);
      addr_ph(32'h200, 1'b0, HSIZE_WORD); tick();
      idle();
      chk("rd_lanes_ram", hrdata0, 32'h5566_AA44);
      tick();

      addr_ph(32'h40, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'h1234_5678; addr_ph(32'h40, 1'b0, HSIZE_WORD); tick();
      idle();
      chk("fwd_b2b", hrdata0, 32'h1234_5678);
      chk("fwd_ready", 32'(hreadyout0), 32'd1);
      tick();
      addr_ph(32'h44, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'h0000_0009; idle();
      chk("hold_wr", hrdata0, 32'h1234_5678);
      tick();

      addr_ph(32'h202, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'hFFFF_FFFF; idle();
      chk("mis_err1_ready", 32'(hreadyout0), 32'd0);
      chk("mis_err1_resp",  32'(hresp0),     32'd1);
      tick();
      chk("mis_err2_ready", 32'(hreadyout0), 32'd1);
      chk("mis_err2_resp",  32'(hresp0),     32'd1);
      chk("hold_err", hrdata0, 32'h1234_5678);
      tick();
      chk("mis_after_resp", 32'(hresp0), 32'd0);

      addr_ph(32'h8000, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'hFFFF_FFFF; idle();
      chk("oor_err1_ready", 32'(hreadyout0), 32'd0);
      chk("oor_err1_resp",  32'(hresp0),     32'd1);
      tick();
      chk("oor_err2_ready", 32'(hreadyout0), 32'd1);
      chk("oor_err2_resp",  32'(hresp0),     32'd1);
      tick();

      addr_ph(32'h0, 1'b0, 3'b011); tick();
      idle();
      chk("size_err_resp", 32'(hresp0), 32'd1);
      tick(); tick();

      addr_ph(32'h200, 1'b0, HSIZE_WORD); tick();
      idle();
      chk("mis_unchanged", hrdata0, 32'h5566_AA44);
      tick();
      addr_ph(32'h0, 1'b0, HSIZE_WORD); tick();
      idle();
      chk("oor_unchanged", hrdata0, 32'h00C0_FFEE);
      tick();

`ifdef AHB_SRAM_WPROT_EN
      wp_lock = 1'b1;
      addr_ph(32'h0, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'hFFFF_FFFF; idle();
      chk("wp_err1_ready", 32'(hreadyout0), 32'd0);
      chk("wp_err1_resp",  32'(hresp0),     32'd1);
      tick();
      chk("wp_err2_ready", 32'(hreadyout0), 32'd1);
      chk("wp_err2_resp",  32'(hresp0),     32'd1);
      tick();
      addr_ph(32'h0, 1'b0, HSIZE_WORD); tick();
      idle();
      chk("wp_rd_old", hrdata0, 32'h00C0_FFEE);
      chk("wp_rd_resp", 32'(hresp0), 32'd0);
      tick();
      wp_lock = 1'b0;
`endif

      hsel0 = 1'b0; hsel1 = 1'b1;
      addr_ph(32'h10, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'hCAFE_F00D; idle();
      chk("ws_first_low", 32'(hreadyout1), 32'd0);
      wait_ready1(n);
      chk("ws_wr_wait", n, 32'd3);
      tick();
      addr_ph(32'h10, 1'b0, HSIZE_WORD); tick();
      idle();
      wait_ready1(n);
      chk("ws_rd_wait", n, 32'd3);
      chk("ws_rd_data", hrdata1, 32'hCAFE_F00D);
      chk("ws_rd_resp", 32'(hresp1), 32'd0);
      tick();

      addr_ph(32'h10, 1'b1, HSIZE_WORD); tick();
      hwdata = 32'h0BAD_BEEF; idle(); tick();
      chk("rst_mid_low", 32'(hreadyout1), 32'd0);
      reset1 = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(hreadyout1), 32'd1);
      chk("rst_mid_resp",  32'(hresp1),     32'd0);
      tick();
      reset1 = 1'b1;
      tick();
      addr_ph(32'h10, 1'b0, HSIZE_WORD); tick();
      idle();
      wait_ready1(n);
      chk("rst_rd_wait", n, 32'd3);
      chk("rst_ram_kept", hrdata1, 32'hCAFE_F00D);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite slave (responder) backing the boot/instruction RAM that the SPI bootloader writes into and the core later reads. It accepts single NONSEQ/SEQ transfers of byte, halfword or word size. It performs byte-lane writes into a synchronous single-port RAM and returns read data in the data phase. Optional wait states are inserted per transfer, and a two-cycle ERROR is returned for illegal accesses.

Parameters:
ADDR_WIDTH, 13, word-address bits; RAM depth = 2^ADDR_WIDTH words (default 32 KB)
BASE_ADDR, 32'h00000000, byte base address of the RAM window; must be aligned to the window size
WAIT_STATES, 0, number of hreadyout-low cycles inserted in every OKAY data phase (0..7)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
hsel  input  1  slave select from the decoder
haddr  input  32  byte address (address phase)
hwrite  input  1  1 = write, 0 = read
hsize  input  3  0 = byte, 1 = halfword, 2 = word; others are illegal
htrans  input  2  IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3
hwdata  input  32  write data (data phase)
hready  input  1  bus-level hready; qualifies the address phase
hreadyout  output  1  slave ready
hresp  output  1  0 = OKAY, 1 = ERROR
hrdata  output  32  read data, valid when hreadyout = 1 in a read data phase

Behaviour:
- Reset (reset = 0, async): hreadyout = 1, hresp = 0, hrdata = 0, all phase registers cleared, FSM = IDLE. RAM contents are not reset. Reset asserted mid-transfer aborts it; no partial RAM write occurs after reset asserts.
- Address phase accepted when hsel & htrans[1] & hready. IDLE/BUSY or hsel = 0 with hready = 1 gives a zero-wait OKAY in the next cycle.
- On accept, latch: word address (haddr[ADDR_WIDTH+1:2]), byte offset, hsize and hwrite. Compute the legal flag:
  - hsize <= 2;
  - aligned: halfword needs haddr[0] = 0, word needs haddr[1:0] = 0;
  - haddr in [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH).
- FSM states IDLE, WAIT, DATA, ERR1, ERR2.
  - Accepted and illegal -> ERR1: hreadyout = 0, hresp = 1. ERR1 -> ERR2: hreadyout = 1, hresp = 1. ERR2 -> IDLE, or straight into the next accepted phase. No RAM write and no RAM state change.
  - Accepted and legal, WAIT_STATES > 0 -> WAIT: counter loads WAIT_STATES, hreadyout = 0 while counter != 0, decrements each cycle, then -> DATA.
  - WAIT_STATES = 0 -> DATA directly: hreadyout = 1, hresp = 0.
  - A new address phase accepted in DATA (pipelined back-to-back) is processed without a bubble.
- Reads: RAM read issued in the cycle hreadyout = 1 for the final data-phase cycle's address. hrdata is the full 32-bit word; the master picks lanes. Read latency is 1 cycle after the address phase with WAIT_STATES = 0.
- Writes: byte enables derived from hsize/offset. Byte -> 1 lane; halfword -> lanes {1:0} or {3:2}; word -> all 4. RAM written at the end of the data phase (hreadyout = 1) using hwdata.
- Read-after-write hazard: a read address phase coinciding with a write data phase to the same word returns the RAM word merged with the enabled hwdata bytes (forwarding). Zero added latency.
- hrdata holds its last value on writes, errors and idle.

Optional Feature:
AHB_SRAM_WPROT_EN. When defined, adds input wp_lock (1 bit). While wp_lock = 1, any accepted legal write takes the two-cycle ERROR response and the RAM is unchanged; reads are unaffected. wp_lock is sampled in the address phase. The intended use is to lock the boot image once the bootloader releases core reset. When undefined, the port is absent and writes are never protected.

Decomposition:
- Shared package ahb_lite_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD, HRESP_OKAY/ERROR, and the FSM state encoding.
- One sub-module sram_1rw_be: synchronous single-port RAM, 32-bit data, 4-bit byte-write enable, 1-cycle registered read, no reset. It is separated so the behavioural array can be swapped for a vendor BRAM macro.

Test Plan:
- Word write 32'hDEADBEEF @0x200, then read @0x200 (WAIT_STATES = 0) -> OKAY, hrdata = 32'hDEADBEEF one cycle after the read address phase.
- Byte write 8'hAA @0x201 over word 0x11223344 @0x200, then halfword write 16'h5566 @0x202 -> read gives 32'h5566AA44.
- Back-to-back write 0x12345678 @0x40, then read @0x40 in the next cycle -> hrdata = 0x12345678 via forwarding, no stall.
- Word access @0x202, and access @BASE_ADDR + 0x8000 -> hreadyout = 0/hresp = 1 then hreadyout = 1/hresp = 1; following read of the prior contents is unchanged.
- WAIT_STATES = 3, read @0x10 -> exactly 3 hreadyout-low cycles, then data; reset asserted during cycle 2 -> hreadyout = 1, hresp = 0 immediately, RAM unchanged.
- AHB_SRAM_WPROT_EN defined, wp_lock = 1, write 0xFFFFFFFF @0x0 -> two-cycle ERROR; read returns the old value.
